// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimation filter (integrator and comb sections).
// Holds the default filter geometry and the accumulator width rule.
package cic_pkg;

  localparam int CIC_N        = 3;
  localparam int CIC_R        = 8;
  localparam int CIC_IN_WIDTH = 8;

  // Bit growth of an N-stage CIC with differential delay 1 is N*clog2(R).
  function automatic int cic_out_width(input int in_w, input int n, input int r);
    return in_w + n * $clog2(r);
  endfunction

  localparam int CIC_OUT_WIDTH = cic_out_width(CIC_IN_WIDTH, CIC_N, CIC_R);

endpackage

// File: rtl/cic_integ_decim_integrator.sv
// Single CIC integrator stage: a modular accumulator that advances only when
// ena is high. Wrap-around is intentional; the comb section cancels it.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset, clears the accumulator
//   ena    - advance qualifier
//   x_in   - addend (already at accumulator width)
//   y_out  - registered accumulator value
module cic_integrator #(
  parameter int WIDTH = 17
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ena,
  input  logic [WIDTH-1:0] x_in,
  output logic [WIDTH-1:0] y_out
);

  logic [WIDTH-1:0] r_acc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (ena) begin
      r_acc <= r_acc + x_in;
    end
  end

  assign y_out = r_acc;

endmodule

// File: rtl/cic_integ_decim.sv
// Integrator + decimator front end of the CIC decimation filter.
// N pipelined integrators run at the input rate; every R enabled cycles the
// last integrator's registered value is captured into y_out with a one-cycle
// valid strobe for the low-rate comb section.
// Ports:
//   clock     - rising-edge clock
//   reset     - asynchronous active-low reset
//   ena       - input sample qualifier; nothing advances while low
//   x_in      - signed input sample (IN_WIDTH)
//   y_out     - signed decimated integrator output (OUT_WIDTH), wraps
//   valid_out - one-cycle strobe when y_out has just been updated
module cic_integ_decim
  import cic_pkg::*;
#(
  parameter int IN_WIDTH  = CIC_IN_WIDTH,
  parameter int N         = CIC_N,
  parameter int R         = CIC_R,
  parameter int OUT_WIDTH = cic_out_width(IN_WIDTH, N, R)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ena,
  input  logic [IN_WIDTH-1:0]  x_in,
  output logic [OUT_WIDTH-1:0] y_out,
  output logic                 valid_out
);

  localparam int CW = $clog2(R);

  if (N < 1) begin : g_bad_n
    $error("cic_integ_decim: N must be at least 1");
  end
  if (R < 2) begin : g_bad_r
    $error("cic_integ_decim: R must be at least 2");
  end
  if (OUT_WIDTH <= IN_WIDTH) begin : g_bad_w
    $error("cic_integ_decim: OUT_WIDTH must exceed IN_WIDTH");
  end

  // w_stage[0] is the sign-extended input; w_stage[k+1] is integrator k.
  logic [OUT_WIDTH-1:0] w_stage [0:N];
  logic                 w_last;

  logic [CW-1:0]        r_cnt;
  logic [OUT_WIDTH-1:0] r_y;
  logic                 r_valid;

  // Gating the extended sample with ena keeps an undriven x_in out of the
  // accumulators during stalls, even though they would not load it anyway.
  assign w_stage[0] = ena ? {{(OUT_WIDTH-IN_WIDTH){x_in[IN_WIDTH-1]}}, x_in}
                          : '0;

  for (genvar k = 0; k < N; k++) begin : g_integ
    cic_integrator #(
      .WIDTH (OUT_WIDTH)
    ) u_integ (
      .clock (clock),
      .reset (reset),
      .ena   (ena),
      .x_in  (w_stage[k]),
      .y_out (w_stage[k+1])
    );
  end

  assign w_last = (r_cnt == CW'(R - 1));

  // Explicit wrap so non-power-of-two R works with the same counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (ena) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  // Captures the last stage's value from before this edge's accumulate.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= ena && w_last;
      if (ena && w_last) begin
        r_y <= w_stage[N];
      end
    end
  end

  assign y_out     = r_y;
  assign valid_out = r_valid;

endmodule

// File: tb/tb_cic_integ_decim.sv
module tb_cic_integ_decim;
  import cic_pkg::*;

  localparam int N  = CIC_N;
  localparam int R  = CIC_R;
  localparam int IW = CIC_IN_WIDTH;
  localparam int OW = CIC_OUT_WIDTH;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ena   = 1'b0;
  logic [IW-1:0] x_in  = '0;
  logic [OW-1:0] y_out;
  logic          valid_out;

  cic_integ_decim dut (
    .clock     (clock),
    .reset     (reset),
    .ena       (ena),
    .x_in      (x_in),
    .y_out     (y_out),
    .valid_out (valid_out)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: all enabled samples since reset, and the expectations
  // derived from them. The last integrator after t updates holds
  // sum_i x_i * C(t-1-i, N-1) (mod 2^OW) over the first t samples.
  longint        q_in[$];
  int            n_en;
  int            n_cyc;
  logic [OW-1:0] exp_y;
  logic          exp_v;

  function automatic longint binom(input longint n, input int k);
    longint res;
    if (n < k) return 0;
    res = 1;
    for (int j = 0; j < k; j++) res = res * (n - j) / (j + 1);
    return res;
  endfunction

  function automatic logic [OW-1:0] model_y(input int t);
    longint acc;
    acc = 0;
    for (int i = 0; i < t; i++) acc += q_in[i] * binom(t - 1 - i, N - 1);
    return acc[OW-1:0];
  endfunction

  task automatic model_clear();
    q_in.delete();
    n_en  = 0;
    n_cyc = 0;
    exp_y = '0;
    exp_v = 1'b0;
  endtask

  // Drive one cycle, advance the model; leaves time at posedge+1.
  task automatic step(input logic e, input logic [IW-1:0] x);
    ena  = e;
    x_in = x;
    @(posedge clock);
    n_cyc++;
    exp_v = 1'b0;
    if (e) begin
      n_en++;
      if (n_en % R == 0) begin
        exp_y = model_y(n_en - 1);
        exp_v = 1'b1;
      end
      q_in.push_back(longint'($signed(x)));
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    ena   = 1'b0;
    model_clear();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    n_vec++;
    if (y_out !== '0) begin
      n_err++;
      $display("FAIL reset_y: got %0h want 0", y_out);
    end
    n_vec++;
    if (valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid: got %b want 0", valid_out);
    end
    model_clear();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_ramp();
    logic [OW-1:0] want [3];
    int sidx;
    want = '{OW'(35), OW'(455), OW'(1771)};
    sidx = 0;
    apply_reset();
    for (int c = 0; c < 24; c++) begin
      step(1'b1, IW'(1));
      n_vec++;
      if (valid_out !== exp_v || y_out !== exp_y) begin
        n_err++;
        $display("FAIL ramp_model cyc %0d: got v=%b y=%0d want v=%b y=%0d",
                 n_cyc, valid_out, y_out, exp_v, exp_y);
      end
      if (valid_out && sidx < 3) begin
        n_vec++;
        if (y_out !== want[sidx] || n_en != 8 * (sidx + 1)) begin
          n_err++;
          $display("FAIL ramp_const %0d: got y=%0d at edge %0d want y=%0d at edge %0d",
                   sidx, y_out, n_en, want[sidx], 8 * (sidx + 1));
        end
        sidx++;
      end
    end
    n_vec++;
    if (sidx != 3) begin
      n_err++;
      $display("FAIL ramp_count: got %0d strobes want 3", sidx);
    end
  endtask

  task automatic test_negative();
    logic [OW-1:0] want [2];
    int sidx;
    want = '{17'h1FFDD, 17'h1FE39};
    sidx = 0;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      step(1'b1, 8'hFF);
      n_vec++;
      if (valid_out !== exp_v || y_out !== exp_y) begin
        n_err++;
        $display("FAIL neg_model cyc %0d: got v=%b y=%0h want v=%b y=%0h",
                 n_cyc, valid_out, y_out, exp_v, exp_y);
      end
      if (valid_out && sidx < 2) begin
        n_vec++;
        if (y_out !== want[sidx]) begin
          n_err++;
          $display("FAIL neg_const %0d: got %0h want %0h", sidx, y_out, want[sidx]);
        end
        sidx++;
      end
    end
    n_vec++;
    if (sidx != 2) begin
      n_err++;
      $display("FAIL neg_count: got %0d strobes want 2", sidx);
    end
  endtask

  task automatic test_gaps();
    int cyc_want [2];
    logic [OW-1:0] want [2];
    int sidx;
    cyc_want = '{15, 31};
    want     = '{OW'(35), OW'(455)};
    sidx = 0;
    apply_reset();
    for (int c = 0; c < 34; c++) begin
      if (c % 2 == 0) step(1'b1, IW'(1));
      else            step(1'b0, IW'($urandom));
      n_vec++;
      if (valid_out !== exp_v || y_out !== exp_y) begin
        n_err++;
        $display("FAIL gap_model cyc %0d: got v=%b y=%0d want v=%b y=%0d",
                 n_cyc, valid_out, y_out, exp_v, exp_y);
      end
      if (valid_out && sidx < 2) begin
        n_vec++;
        if (y_out !== want[sidx] || n_cyc != cyc_want[sidx]) begin
          n_err++;
          $display("FAIL gap_const %0d: got y=%0d cyc %0d want y=%0d cyc %0d",
                   sidx, y_out, n_cyc, want[sidx], cyc_want[sidx]);
        end
        sidx++;
      end
    end
    n_vec++;
    if (sidx != 2) begin
      n_err++;
      $display("FAIL gap_count: got %0d strobes want 2", sidx);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int c = 0; c < 13; c++) step(1'b1, IW'(1));
    n_vec++;
    if (y_out !== OW'(35)) begin
      n_err++;
      $display("FAIL midrst_pre: got %0d want 35", y_out);
    end
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if (y_out !== '0 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_async: got v=%b y=%0d want v=0 y=0", valid_out, y_out);
    end
    model_clear();
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step(1'b1, IW'(1));
      n_vec++;
      if (valid_out !== exp_v || y_out !== exp_y) begin
        n_err++;
        $display("FAIL midrst_model cyc %0d: got v=%b y=%0d want v=%b y=%0d",
                 n_cyc, valid_out, y_out, exp_v, exp_y);
      end
    end
    n_vec++;
    if (valid_out !== 1'b1 || y_out !== OW'(35)) begin
      n_err++;
      $display("FAIL midrst_first: got v=%b y=%0d want v=1 y=35", valid_out, y_out);
    end
  endtask

  task automatic test_wrap();
    logic [OW-1:0] ys[$];
    logic [OW-1:0] comb;
    int n;
    apply_reset();
    for (int c = 0; c < 4096; c++) begin
      step(1'b1, 8'h7F);
      n_vec++;
      if (valid_out !== exp_v || y_out !== exp_y) begin
        n_err++;
        $display("FAIL wrap_model cyc %0d: got v=%b y=%0h want v=%b y=%0h",
                 n_cyc, valid_out, y_out, exp_v, exp_y);
      end
      if (valid_out) begin
        ys.push_back(y_out);
        n = ys.size() - 1;
        if (n >= 3) begin
          comb = ys[n] - OW'(3) * ys[n-1] + OW'(3) * ys[n-2] - ys[n-3];
          n_vec++;
          if (comb !== OW'(65024)) begin
            n_err++;
            $display("FAIL wrap_comb strobe %0d: got %0d want 65024", n, comb);
          end
        end
      end
    end
    n_vec++;
    if (ys.size() != 512) begin
      n_err++;
      $display("FAIL wrap_count: got %0d strobes want 512", ys.size());
    end
  endtask

  task automatic test_impulse();
    logic [OW-1:0] want [2];
    int sidx;
    want = '{OW'(15), OW'(91)};
    sidx = 0;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      step(1'b1, (c == 0) ? IW'(1) : IW'(0));
      n_vec++;
      if (valid_out !== exp_v || y_out !== exp_y) begin
        n_err++;
        $display("FAIL imp_model cyc %0d: got v=%b y=%0d want v=%b y=%0d",
                 n_cyc, valid_out, y_out, exp_v, exp_y);
      end
      if (valid_out && sidx < 2) begin
        n_vec++;
        if (y_out !== want[sidx]) begin
          n_err++;
          $display("FAIL imp_const %0d: got %0d want %0d", sidx, y_out, want[sidx]);
        end
        sidx++;
      end
    end
  endtask

  task automatic test_random();
    logic prev_v;
    prev_v = 1'b0;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      step(($urandom % 4) != 0, IW'($urandom));
      n_vec++;
      if (valid_out !== exp_v || y_out !== exp_y) begin
        n_err++;
        $display("FAIL rand_model cyc %0d: got v=%b y=%0h want v=%b y=%0h",
                 n_cyc, valid_out, y_out, exp_v, exp_y);
      end
      n_vec++;
      if (prev_v && valid_out) begin
        n_err++;
        $display("FAIL rand_b2b cyc %0d: got two consecutive strobes want isolated", n_cyc);
      end
      prev_v = valid_out;
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_ramp();
    test_negative();
    test_gaps();
    test_mid_reset();
    test_wrap();
    test_impulse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
